hart_mem_arb: RTL and testbench
===============================

HART_MEM_ARB -- requirements
Module: hart_mem_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of DATA_W words in the shared array.
REQ-004 SHALL have parameter WAIT, default 0, range 0..15, wait-state cycles per access.
REQ-005 SHALL have parameter INIT_FILE, default "", hex image loaded into the array at elaboration when non-empty.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have instruction ports: if_req in 1 fetch request; if_addr in ADDR_W byte address; if_gnt out 1 request accepted; if_rvalid out 1 response valid; if_rdata out DATA_W fetched word; if_err out 1 access fault.
REQ-008 SHALL have data ports: d_req in 1; d_we in 1 write when high; d_be in DATA_W/8 byte enables; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W; d_err out 1.

Function
REQ-009 SHALL serve one access at a time from a single array, with FSM states IDLE, WAIT, RESP.
REQ-010 SHALL assert exactly one of if_gnt/d_gnt, for one cycle, only in IDLE with that port's req high; the state then goes to WAIT if WAIT>0, else RESP.
REQ-011 SHALL remain in WAIT for exactly WAIT cycles using a down-counter, then enter RESP.
REQ-012 SHALL pulse the granted port's rvalid for one cycle in RESP, then return to IDLE; the response for a grant in cycle k arrives in cycle k+1+WAIT.
REQ-013 SHALL treat requesters as holding req and addr/data stable until gnt; fields SHALL be captured at the grant edge, and later input changes SHALL NOT affect the access.
REQ-014 SHALL, on simultaneous if_req and d_req in IDLE, grant the port not granted on the previous conflict (round-robin flag); a single requester SHALL always win.
REQ-015 SHALL compute word index = addr >> log2(DATA_W/8).
REQ-016 SHALL flag a fault when addr low log2(DATA_W/8) bits are nonzero or word index >= DEPTH.
REQ-017 On a fault, SHALL leave the array untouched and drive err=1 and rdata=0 alongside rvalid.
REQ-018 For a read, SHALL drive rdata with the array word and err=0 in RESP.
REQ-019 For a write, SHALL update only lanes with d_be set, committed at the edge entering RESP, drive d_rdata=0 in RESP, and pulse d_rvalid as the write acknowledgement.
REQ-020 SHALL hold rdata/err at 0 whenever the port's rvalid is low.
REQ-021 SHALL NOT allow instruction fetches to write; if_* is read-only.
REQ-022 SHALL NOT issue any grant during WAIT or RESP; requests arriving then wait for IDLE.

Reset
REQ-023 rst high SHALL immediately force IDLE, counter 0, round-robin flag to data-first, and all gnt/rvalid/err/rdata outputs to 0.
REQ-024 Reset during WAIT SHALL abort the access: no write commit, no rvalid after release.
REQ-025 Array contents SHALL NOT be cleared by reset.

Verification
REQ-026 WAIT=0, INIT_FILE word0=0x00000013: if_req addr 0 -> if_gnt cycle k, if_rvalid cycle k+1, if_rdata=0x00000013, if_err=0.
REQ-027 WAIT=3: d write addr 0x8, wdata 0xAABBCCDD, be=4'b0101, prior word 0 -> ack at k+4; then read addr 0x8 returns 0x00BB00DD.
REQ-028 Both ports request continuously from reset -> grants alternate d, if, d, if; each response precedes the next grant.
REQ-029 d read addr 0x2 (misaligned) and addr 0x400 with DEPTH=256 -> d_rvalid with d_err=1, d_rdata=0; array unchanged.
REQ-030 WAIT=5: write granted, rst asserted 2 cycles later -> outputs 0 at once, no d_rvalid after release, target word keeps old value.
REQ-031 d_addr changed in cycle after grant -> access and response use the captured address.

Source files
------------

// File: rtl/hart_mem_arb.sv
// rtl/hart_mem_arb.sv - shared single-port word memory arbitrated between instruction and data ports
module hart_mem_arb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int WAIT      = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction fetch port (read-only)
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DATA_W-1:0]    if_rdata,
    output logic                 if_err,
    // data port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [DATA_W/8-1:0]  d_be,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    // misaligned or beyond the array
    function automatic logic f_fault(input logic [ADDR_W-1:0] a);
        return ((a & OFF_MASK) != '0) || ((a >> OFF) >= DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF);
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_prio_d;
    logic              r_is_d;
    logic              r_we;
    logic              r_fault;
    logic [IDX_W-1:0]  r_idx;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;

    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    logic              w_idle;
    logic              w_conflict;
    logic              w_pick_d;
    logic              w_pick_if;
    logic              w_grant;
    logic [ADDR_W-1:0] w_g_addr;
    logic              w_g_we;
    logic              w_enter_resp;
    logic              w_a_is_d;
    logic              w_a_we;
    logic              w_a_fault;
    logic [IDX_W-1:0]  w_a_idx;
    logic [NB-1:0]     w_a_be;
    logic [DATA_W-1:0] w_a_wdata;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_commit;

    // Arbitration: a lone requester always wins; on a conflict the round-robin flag decides.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_conflict = if_req && d_req;
    assign w_pick_d   = d_req && (!if_req || r_prio_d);
    assign w_pick_if  = if_req && !w_pick_d;
    assign d_gnt      = w_idle && w_pick_d;
    assign if_gnt     = w_idle && w_pick_if;
    assign w_grant    = d_gnt || if_gnt;
    assign w_g_addr   = w_pick_d ? d_addr : if_addr;
    assign w_g_we     = w_pick_d && d_we;

    // With no wait states the access completes on the grant edge itself, so live inputs are used.
    assign w_enter_resp = (WAIT == 0) ? w_grant : ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    assign w_a_is_d     = (WAIT == 0) ? w_pick_d           : r_is_d;
    assign w_a_we       = (WAIT == 0) ? w_g_we             : r_we;
    assign w_a_fault    = (WAIT == 0) ? f_fault(w_g_addr)  : r_fault;
    assign w_a_idx      = (WAIT == 0) ? f_idx(w_g_addr)    : r_idx;
    assign w_a_be       = (WAIT == 0) ? d_be               : r_be;
    assign w_a_wdata    = (WAIT == 0) ? d_wdata            : r_wdata;
    assign w_rd_word    = w_a_fault ? '0 : r_mem[w_a_idx];
    assign w_commit     = w_enter_resp && w_a_is_d && w_a_we && !w_a_fault;

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

    // Access sequencer: capture at grant, count wait states, present a one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_prio_d    <= 1'b1;
            r_is_d      <= 1'b0;
            r_we        <= 1'b0;
            r_fault     <= 1'b0;
            r_idx       <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_is_d  <= w_pick_d;
                        r_we    <= w_g_we;
                        r_fault <= f_fault(w_g_addr);
                        r_idx   <= f_idx(w_g_addr);
                        r_be    <= d_be;
                        r_wdata <= d_wdata;
                        if (w_conflict) r_prio_d <= !r_prio_d;
                        if (WAIT == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_enter_resp) begin
                if (w_a_is_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= w_a_fault;
                    r_d_rdata  <= w_a_we ? '0 : w_rd_word;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_err    <= w_a_fault;
                    r_if_rdata  <= w_rd_word;
                end
            end
        end
    end

    // Byte-lane write into the array on the edge that enters RESP; the array is never reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (w_a_be[b]) r_mem[w_a_idx][b*8 +: 8] <= w_a_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_hart_mem_arb.sv
// tb/tb_hart_mem_arb.sv - directed table-driven bench for hart_mem_arb
module tb_hart_mem_arb;

    localparam int LAT3 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        w0_if_gnt, w0_if_rvalid, w0_if_err, w0_d_gnt, w0_d_rvalid, w0_d_err;
    logic [31:0] w0_if_rdata, w0_d_rdata;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    hart_mem_arb #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    hart_mem_arb #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(w0_if_gnt), .if_rvalid(w0_if_rvalid),
        .if_rdata(w0_if_rdata), .if_err(w0_if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(w0_d_gnt), .d_rvalid(w0_d_rvalid), .d_rdata(w0_d_rdata), .d_err(w0_d_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One access; starts and ends 1 time unit after a rising edge.
    task automatic access(input logic is_d, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic ok, output logic post_rv, output logic [31:0] post_rd);
        int   gcyc;
        logic got;
        ok = 1'b0; lat = -1; rdata = '0; err = 1'b0; post_rv = 1'b0; post_rd = '0; gcyc = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (is_d ? d_gnt : if_gnt) begin
                got = 1'b1; gcyc = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            d_req = 1'b0; if_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Inputs change right after the grant; the access must use the captured values.
        d_req = 1'b0; if_req = 1'b0;
        d_addr = 32'hFFFF_FFF0; if_addr = 32'h0000_0FF0;
        d_wdata = 32'h5A5A_5A5A; d_be = 4'hF; d_we = ~d_we;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (is_d ? d_rvalid : if_rvalid) begin
                got = 1'b1; lat = cyc - gcyc;
                rdata = is_d ? d_rdata : if_rdata;
                err = is_d ? d_err : if_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) return;
        ok = 1'b1;
        @(posedge clk); #1;
        post_rv = is_d ? d_rvalid : if_rvalid;
        post_rd = is_d ? d_rdata : if_rdata;
    endtask

    vec_t        vecs [16];
    logic [31:0] rd, post_rd;
    logic        er, ok, post_rv;
    int          lat, k, cnt;
    int          gport [8], gcy [8], rport [8], rcy [8];
    logic [31:0] rdat [8];
    int          ng, nr;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h008, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'h5, 32'h008, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h008, 32'h0,         32'h00BB_00DD, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 32'h008, 32'h0,         32'h00BB_00DD, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h3FC, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h3FC, 32'h0,         32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'hF, 32'h004, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'h002, 32'h0,         32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'h400, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h006, 32'hBEEF_BEEF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h002, 32'h0,         32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h004, 32'h0,         32'h1122_3344, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h000, 32'h0,         32'h0000_0013, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'h8, 32'h008, 32'h7700_0000, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 32'h008, 32'h0,         32'h77BB_00DD, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 32'h400, 32'h0,         32'h0000_0000, 1'b1};

        // Reset state, with both requests high while reset is held
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_err", {30'b0, if_err, d_err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        do_reset();

        // Put 0x13 at word 0 in both instances, then fetch it
        access(1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_0013, rd, er, lat, ok, post_rv, post_rd);
        chk("init_wr_ok", {31'b0, ok}, 32'd1);
        chk("init_wr_lat", lat, LAT3);
        if_req = 1'b1; if_addr = 32'h0;
        #1;
        chk("fetch_gnt_w3", {31'b0, if_gnt}, 32'd1);
        chk("fetch_gnt_w0", {31'b0, w0_if_gnt}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = 32'h0000_0FF0;
        #1;
        chk("w0_rvalid_k1", {31'b0, w0_if_rvalid}, 32'd1);
        chk("w0_rdata", w0_if_rdata, 32'h0000_0013);
        chk("w0_err", {31'b0, w0_if_err}, 32'd0);
        chk("w3_rvalid_k1", {31'b0, if_rvalid}, 32'd0);
        cnt = 0;
        for (int n = 0; n < 12 && cnt == 0; n++) begin
            @(posedge clk); #2;
            if (if_rvalid) begin
                cnt = n + 2;
                chk("w3_fetch_rdata", if_rdata, 32'h0000_0013);
            end
        end
        chk("w3_fetch_lat", cnt, LAT3);
        @(posedge clk); #1;

        // Table of single accesses on the WAIT=3 instance
        foreach (vecs[i]) begin
            access(vecs[i].is_d, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, ok, post_rv, post_rd);
            chk($sformatf("v%0d_done", i), {31'b0, ok}, 32'd1);
            chk($sformatf("v%0d_lat", i), lat, LAT3);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_post_rvalid", i), {31'b0, post_rv}, 32'd0);
            chk($sformatf("v%0d_post_rdata", i), post_rd, 32'd0);
        end

        // Round-robin: both ports request continuously from reset
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h8;
        if_req = 1'b1; if_addr = 32'h0;
        ng = 0; nr = 0;
        for (int n = 0; n < 26; n++) begin
            #1;
            if (d_gnt && ng < 8) begin gport[ng] = 1; gcy[ng] = cyc; ng++; end
            if (if_gnt && ng < 8) begin gport[ng] = 0; gcy[ng] = cyc; ng++; end
            if (d_rvalid && nr < 8) begin rport[nr] = 1; rcy[nr] = cyc; rdat[nr] = d_rdata; nr++; end
            if (if_rvalid && nr < 8) begin rport[nr] = 0; rcy[nr] = cyc; rdat[nr] = if_rdata; nr++; end
            @(posedge clk); #1;
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("rr_grant_count", {31'b0, ng >= 4}, 32'd1);
        chk("rr_resp_count", {31'b0, nr >= 4}, 32'd1);
        if (ng >= 4 && nr >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_g%0d_port", i), gport[i], (i % 2 == 0) ? 1 : 0);
                chk($sformatf("rr_r%0d_port", i), rport[i], gport[i]);
                chk($sformatf("rr_r%0d_cyc", i), rcy[i], gcy[i] + LAT3);
                chk($sformatf("rr_r%0d_data", i), rdat[i],
                    (i % 2 == 0) ? 32'h77BB_00DD : 32'h0000_0013);
                if (i < 3) chk($sformatf("rr_gap%0d", i), gcy[i+1] - gcy[i], LAT3 + 1);
            end
        end
        do_reset();

        // Reset during WAIT aborts a write
        access(1'b1, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, rd, er, lat, ok, post_rv, post_rd);
        chk("ab_setup_ok", {31'b0, ok}, 32'd1);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'h0;
        #1;
        chk("ab_gnt", {31'b0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("ab_rst_outs", {28'b0, d_gnt, d_rvalid, d_err, if_rvalid}, 32'd0);
        chk("ab_rst_rdata", d_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (d_rvalid) cnt++;
            @(posedge clk); #1;
        end
        chk("ab_no_rvalid", cnt, 0);
        access(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, ok, post_rv, post_rd);
        chk("ab_word_kept", rd, 32'hCAFE_F00D);

        // Reset asserted during RESP clears the response immediately
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        #1;
        chk("rr_resp_gnt", {31'b0, d_gnt}, 32'd1);
        k = 0;
        repeat (4) begin @(posedge clk); #1; d_req = 1'b0; end
        #1;
        chk("resp_rvalid_before", {31'b0, d_rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("resp_rvalid_after_rst", {31'b0, d_rvalid}, 32'd0);
        chk("resp_rdata_after_rst", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
